// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - show-ahead FIFO reader feeding a 2-entry register slice with burst last tagging
// Main register drives the stream outputs directly; the skid register absorbs the one extra pop issued before a stall is seen.
module fifo_stream_reader #(
  parameter int W         = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             rd_empty,
  input  logic [W-1:0]                     rd_data,
  output logic                             rd_en,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [W-1:0]                     m_data,
  output logic                             m_last,
  output logic [$clog2(BURST_LEN+1)-1:0]   beat_cnt
);

  localparam int            CW       = $clog2(BURST_LEN+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN-1);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           run;
  logic           pop;
  logic           xfer;
  logic           last_in;
  logic           ld_main_new;
  logic           ld_main_skid;
  logic           ld_skid;
  logic [W-1:0]   skid_data;
  logic           skid_last;

  // run keeps rd_en low until the first clock edge after reset release
  assign rd_en   = run & ~rd_empty & (state != FULL);
  assign pop     = rd_en & ~rd_empty;
  assign xfer    = m_valid & m_ready;
  assign last_in = (beat_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EMPTY;
      run      <= 1'b0;
      m_valid  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      run     <= 1'b1;
      state   <= state_nxt;
      m_valid <= (state_nxt != EMPTY);
      if (pop) beat_cnt <= last_in ? '0 : beat_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_main_new  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (pop) begin
          ld_main_new = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (pop && xfer) begin
          ld_main_new = 1'b1;
        end else if (pop) begin
          ld_skid   = 1'b1;
          state_nxt = FULL;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          ld_main_skid = 1'b1;
          state_nxt    = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data    <= '0;
      m_last    <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      if (ld_main_new) begin
        m_data <= rd_data;
        m_last <= last_in;
      end else if (ld_main_skid) begin
        m_data <= skid_data;
        m_last <= skid_last;
      end
      if (ld_skid) begin
        skid_data <= rd_data;
        skid_last <= last_in;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - queue-model bench for fifo_stream_reader at BURST_LEN 4 and 1
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rd_empty;
  logic [7:0] rd_data;
  logic       m_ready;

  logic       rd_en4, m_valid4, m_last4;
  logic [7:0] m_data4;
  logic [2:0] beat_cnt4;
  logic       rd_en1, m_valid1, m_last1;
  logic [7:0] m_data1;
  logic [0:0] beat_cnt1;

  always #5 clk = ~clk;

  fifo_stream_reader #(.W(8), .BURST_LEN(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .rd_empty(rd_empty), .rd_data(rd_data), .rd_en(rd_en4),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4), .beat_cnt(beat_cnt4)
  );

  fifo_stream_reader #(.W(8), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rd_empty(rd_empty), .rd_data(rd_data), .rd_en(rd_en1),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .beat_cnt(beat_cnt1)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] src[$];
  beat_t      got[$];
  int         got_cyc[$];
  int         pops;
  int         dut_pops;
  int         got1_bad;
  int         cyc;
  int         checks;
  int         errors;
  bit         run_exp;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       rst_seen = 1'b0;

  always @(posedge clk) rst_seen <= reset_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit gate, input bit rdy);
    bit exp_rd;
    bit exp_xfer;
    @(negedge clk);
    cyc++;
    run_exp = rst_seen && reset_n;
    if (!reset_n) begin
      exp_q.delete();
      pops = 0;
    end
    chk("m_valid", m_valid4, exp_q.size() != 0);
    chk("m_valid_b1", m_valid1, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("m_data", m_data4, exp_q[0].d);
      chk("m_last", m_last4, exp_q[0].l);
      chk("m_data_b1", m_data1, exp_q[0].d);
      chk("m_last_b1", m_last1, 1);
    end
    if (!reset_n) begin
      chk("rst_m_data", m_data4, 0);
      chk("rst_m_last", m_last4, 0);
    end
    if (prev_stall) chk("stall_hold", m_data4, prev_data);
    chk("beat_cnt", beat_cnt4, pops % 4);
    chk("beat_cnt_b1", beat_cnt1, 0);

    rd_empty = gate || (src.size() == 0);
    rd_data  = (src.size() != 0) ? src[0] : 8'($urandom);
    m_ready  = rdy;
    #1;
    exp_rd   = run_exp && !rd_empty && (exp_q.size() < 2);
    exp_xfer = (exp_q.size() != 0) && m_ready;
    chk("rd_en", rd_en4, exp_rd);
    chk("rd_en_b1", rd_en1, exp_rd);

    prev_stall = m_valid4 && !m_ready;
    prev_data  = m_data4;
    if (m_valid4 && m_ready) begin
      got.push_back('{d: m_data4, l: m_last4});
      got_cyc.push_back(cyc);
      if (!m_last1) got1_bad++;
    end
    if (rd_en4 && !rd_empty) begin
      void'(src.pop_front());
      dut_pops++;
    end
    if (exp_xfer) void'(exp_q.pop_front());
    if (exp_rd) begin
      exp_q.push_back('{d: rd_data, l: (pops % 4) == 3});
      pops++;
    end
  endtask

  task automatic async_reset();
    #2;
    reset_n    = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("rst_now_m_valid", m_valid4, 0);
    chk("rst_now_rd_en", rd_en4, 0);
    chk("rst_now_beat_cnt", beat_cnt4, 0);
    chk("rst_now_m_valid_b1", m_valid1, 0);
    chk("rst_now_rd_en_b1", rd_en1, 0);
    repeat (2) cycle(1'b0, 1'b1);
    reset_n = 1'b1;
  endtask

  task automatic clear_logs();
    got.delete();
    got_cyc.delete();
    dut_pops = 0;
    got1_bad = 0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; pops = 0;
    dut_pops = 0; got1_bad = 0; prev_stall = 0; prev_data = 0;
    reset_n = 1'b0; rd_empty = 1'b1; rd_data = 8'h00; m_ready = 1'b0;

    // streaming: 0x01..0x08 at full rate, last on 0x04 and 0x08
    for (int i = 1; i <= 8; i++) src.push_back(8'(i));
    repeat (3) cycle(1'b0, 1'b1);
    reset_n = 1'b1;
    clear_logs();
    repeat (12) cycle(1'b0, 1'b1);
    chk("stream_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("stream_data", got[i].d, i + 1);
      chk("stream_last", got[i].l, (i == 3) || (i == 7));
      chk("stream_gapless", got_cyc[i], got_cyc[0] + i);
    end
    chk("b1_every_last", got1_bad, 0);

    // backpressure: three queued beats, sink stalled
    async_reset();
    clear_logs();
    src = '{8'hA1, 8'hB2, 8'hC3};
    repeat (5) cycle(1'b0, 1'b0);
    chk("bp_pops", dut_pops, 2);
    chk("bp_rd_en", rd_en4, 0);
    chk("bp_hold_data", m_data4, 8'hA1);
    repeat (5) cycle(1'b0, 1'b1);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_d0", got[0].d, 8'hA1);
      chk("bp_d1", got[1].d, 8'hB2);
      chk("bp_d2", got[2].d, 8'hC3);
      chk("bp_gapless", got_cyc[2], got_cyc[0] + 2);
    end

    // reset while FULL discards both beats; next beat starts a new burst
    src = '{8'h10, 8'h11, 8'h12, 8'h13};
    repeat (4) cycle(1'b0, 1'b0);
    async_reset();
    clear_logs();
    repeat (4) cycle(1'b0, 1'b1);
    chk("post_rst_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("post_rst_d0", got[0].d, 8'h12);
      chk("post_rst_l0", got[0].l, 0);
    end
    chk("post_rst_beat_cnt", beat_cnt4, 2);

    // upstream empty every other cycle
    clear_logs();
    for (int i = 0; i < 6; i++) src.push_back(8'(8'h30 + i));
    for (int i = 0; i < 16; i++) cycle(i[0], 1'b1);
    chk("toggle_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("toggle_data", got[i].d, 8'h30 + i);

    // random upstream availability and downstream readiness
    for (int i = 0; i < 10000; i++) begin
      if (src.size() < 4) src.push_back(8'($urandom));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter W, default 8: data width in bits; legal W >= 1.
REQ-002 Parameter BURST_LEN, default 4: beats per burst for m_last tagging; legal BURST_LEN >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is sampled on clk.
REQ-005 rd_empty  input  1  upstream sync FIFO empty flag; 0 means rd_data holds a valid head entry (show-ahead).
REQ-006 rd_data  input  W  upstream FIFO head data; valid whenever rd_empty=0.
REQ-007 rd_en  output  1  pop request to upstream FIFO; one pop per cycle while high and rd_empty=0.
REQ-008 m_valid  output  1  downstream beat valid.
REQ-009 m_ready  input  1  downstream ready; beat transfers on a cycle with m_valid=1 and m_ready=1.
REQ-010 m_data  output  W  downstream beat data.
REQ-011 m_last  output  1  high on the final beat of each BURST_LEN-beat burst.
REQ-012 beat_cnt  output  $clog2(BURST_LEN+1)  beats popped from FIFO in current burst, for debug.

Function
REQ-013 Block SHALL be a 2-entry register slice: main register (drives m_*), skid register; m_valid, m_data, m_last SHALL come straight from flops.
REQ-014 States: EMPTY (0 entries), BUSY (main only), FULL (main and skid).
REQ-015 rd_en SHALL equal (~rd_empty) & (state != FULL); rd_en SHALL NOT depend combinationally on m_ready.
REQ-016 pop = rd_en & ~rd_empty; xfer = m_valid & m_ready.
REQ-017 EMPTY: pop -> load main, go BUSY; no pop -> stay EMPTY.
REQ-018 BUSY: pop & xfer -> load main with new beat, stay BUSY; pop & ~xfer -> load skid, go FULL; ~pop & xfer -> go EMPTY; neither -> hold.
REQ-019 FULL: xfer -> move skid into main, go BUSY; ~xfer -> hold both registers, stall (rd_en=0).
REQ-020 m_valid SHALL be 1 exactly in BUSY and FULL.
REQ-021 Latency: beat popped on cycle N SHALL appear on m_data at cycle N+1 when state was EMPTY or BUSY-with-xfer.
REQ-022 Sustained throughput SHALL be one beat per cycle when rd_empty=0 and m_ready=1 continuously.
REQ-023 m_data/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 Ordering: beats SHALL leave in the exact order popped; no loss, no duplication.
REQ-025 Last-tagging: on each pop, a last bit SHALL be computed as (beat_cnt == BURST_LEN-1) and stored with the entry in main or skid.
REQ-026 beat_cnt SHALL increment on each pop and wrap to 0 on the pop that sets last; BURST_LEN=1 SHALL tag every beat last.
REQ-027 beat_cnt SHALL count pops, not transfers, and SHALL be unaffected by downstream stalls.
REQ-028 No pop SHALL occur when rd_empty=1 regardless of rd_en.

Reset
REQ-029 While reset_n=0: state=EMPTY, m_valid=0, m_last=0, beat_cnt=0, rd_en=0; m_data and skid data SHALL reset to 0.
REQ-030 Reset asserted mid-burst or in FULL SHALL discard both held beats and the partial burst count; first pop after release starts a new burst.
REQ-031 rd_en SHALL stay 0 until the first clk edge after reset_n deasserts.

Verification
REQ-032 Reset: reset_n=0 mid-stream with FULL state -> same cycle m_valid=0, rd_en=0, beat_cnt=0; after release, next beat has beat index 0.
REQ-033 Streaming: BURST_LEN=4, FIFO holds 0x01..0x08, m_ready=1 -> m_data 0x01..0x08 on 8 consecutive cycles, m_last high on 0x04 and 0x08 only.
REQ-034 Backpressure: m_ready=0 with 3 beats queued -> exactly 2 pops then rd_en=0, m_data held at first beat; raise m_ready -> remaining beats delivered in order, no gaps.
REQ-035 Empty upstream: rd_empty toggling every cycle with m_ready=1 -> every available beat delivered once, m_valid drops in gaps, beat_cnt tracks pops.
REQ-036 Random: random rd_empty and m_ready for 10k cycles against a scoreboard -> data order intact, m_last every 4th beat, m_data stable while stalled, no pop on rd_empty=1.
REQ-037 BURST_LEN=1: stream 5 beats -> m_last=1 on every beat, beat_cnt stays 0.
